serial_link_gen2: RTL and testbench
===================================

SERIAL_LINK_GEN2 -- requirements
Module: serial_link_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per transfer (legal range 1..16).
REQ-002 SHALL have parameter DIV_NORMAL, default 511, meaning internal half-period minus one, in clk cycles, at normal speed.
REQ-003 SHALL have parameter DIV_FAST, default 15, meaning internal half-period minus one when fast mode is selected.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser depth on serial_clk_in (legal range 2..4).
REQ-005 SHALL have ports: clk in 1 system clock; rst in 1 synchronous active-high reset; one clock, no other clock domains.
REQ-006 SHALL have ports: sel_sc in 1 SC select; sel_sb in 1 SB select; cpu_wr_n in 1 active-low write strobe.
REQ-007 SHALL have ports: sc_start_in in 1; sc_int_clock_in in 1; sc_fast_in in 1; sb_in in DATA_W, all CPU write data.
REQ-008 SHALL have ports: serial_clk_in in 1 external link clock (asynchronous); serial_data_in in 1 link data in.
REQ-009 SHALL have ports: serial_clk_out out 1; serial_data_out out 1; sb out DATA_W shift register.
REQ-010 SHALL have ports: serial_irq out 1 completion pulse; sc_start, sc_int_clock, sc_fast out 1 SC readback; busy out 1 state != IDLE.

Function
REQ-011 SHALL implement states IDLE, INT_LOW, INT_HIGH, EXT_WAIT; busy = (state != IDLE).
REQ-012 SHALL treat a write as sel && !cpu_wr_n; SC and SB writes in the same cycle SHALL both take effect.
REQ-013 SC write: latch sc_start/sc_int_clock/sc_fast; if sc_start_in=1 -> bit counter=DATA_W, divider reload, serial_clk_out=1, state INT_HIGH (int clock) or EXT_WAIT (ext clock), from any state (restart).
REQ-014 SC write with sc_start_in=0 during a transfer SHALL abort: state IDLE, serial_clk_out=1, no irq, sb keeps its partially shifted value.
REQ-015 SB write SHALL load sb from sb_in in any state; the shift in progress continues from the new value.
REQ-016 Internal divider SHALL reload DIV_FAST when sc_fast=1, else DIV_NORMAL, and count down once per clk; expiry = value 0.
REQ-017 INT_HIGH on expiry: serial_clk_out<=0, serial_data_out<=sb[DATA_W-1], state INT_LOW, divider reload.
REQ-018 INT_LOW on expiry: serial_clk_out<=1, sb<={sb[DATA_W-2:0],serial_data_in}, counter-1, divider reload; if counter was 1 -> serial_irq=1 for one cycle, sc_start<=0, state IDLE; else state INT_HIGH.
REQ-019 Transfer time at internal clock SHALL be exactly 2*(DIV+1)*DATA_W cycles from the write edge to the irq edge.
REQ-020 EXT_WAIT: serial_clk_in passes through SYNC_STAGES flops; an edge is detected by comparing the last two stages.
REQ-021 EXT_WAIT on synchronised falling edge: serial_data_out<=sb[DATA_W-1].
REQ-022 EXT_WAIT on synchronised rising edge: shift in serial_data_in, counter-1; if counter was 1 -> one-cycle irq, sc_start<=0, state IDLE.
REQ-023 Synchroniser SHALL be reloaded with the current serial_clk_in value on an SC start write so that no spurious edge is detected.
REQ-024 In EXT_WAIT, serial_clk_out SHALL stay 1 and the divider SHALL be ignored; changing sc_fast affects only the next internal transfer.
REQ-025 DATA_W=1 SHALL be supported (the shift loads serial_data_in directly into sb[0]).
REQ-026 In IDLE, external edges SHALL be ignored and sb SHALL change only on an SB write.

Reset
REQ-027 On rst: state IDLE; sb=0; sc_start=0; sc_int_clock=0; sc_fast=0; serial_clk_out=1; serial_data_out=1; serial_irq=0; busy=0; counter=0; synchroniser loaded with serial_clk_in.
REQ-028 rst SHALL take priority over CPU writes and over any transfer in progress; no irq is produced by the reset.

Verification
REQ-029 Defaults, SB=0xA5, SC write start=1 int=1 fast=0, serial_data_in=1 -> first serial_clk_out fall at cycle 512, irq pulse at cycle 8192, sb=0xFF, out-bit sequence 1,0,1,0,0,1,0,1.
REQ-030 Same with fast=1, serial_data_in=0 -> irq at cycle 256, sb=0x00, sc_start=0 in the irq cycle.
REQ-031 Ext clock, SB=0x3C, 8 serial_clk_in pulses of 20 cycles low/20 high carrying 0x96 -> sb=0x96, one irq, serial_data_out bits 0,0,1,1,1,1,0,0.
REQ-032 Int transfer, SC write start=0 at cycle 3000 -> busy=0 the next cycle, serial_clk_out=1, no irq through cycle 10000.
REQ-033 SB write of 0x00 at cycle 4000 mid-transfer, plus rst at a later mid-transfer point -> bits from the new value go out; after rst all outputs match REQ-027 and there is no irq.
REQ-034 DATA_W=1, DIV_NORMAL=3, serial_data_in=1 -> irq at cycle 8, sb=1.

Source files
------------

// File: rtl/serial_link_gen2.sv
// serial_link_gen2: CPU-programmed serial shift link.
// A transfer shifts DATA_W bits of sb MSB-first out on serial_data_out and shifts
// serial_data_in into sb LSB-first. The bit clock is either generated internally
// from a divider, or taken from the asynchronous serial_clk_in.
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   sel_sc, sel_sb, cpu_wr_n    CPU register selects and active-low write strobe
//   sc_start_in, sc_int_clock_in, sc_fast_in, sb_in   CPU write data
//   serial_clk_in, serial_data_in                     link inputs (clock is async)
//   serial_clk_out, serial_data_out                   link outputs
//   sb                          shift register contents
//   serial_irq                  one-cycle completion pulse
//   sc_start, sc_int_clock, sc_fast, busy             control readback and status
`timescale 1ns/1ps
module serial_link_gen2 #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DIV_NORMAL  = 511,
  parameter int unsigned DIV_FAST    = 15,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_sc,
  input  logic              sel_sb,
  input  logic              cpu_wr_n,
  input  logic              sc_start_in,
  input  logic              sc_int_clock_in,
  input  logic              sc_fast_in,
  input  logic [DATA_W-1:0] sb_in,
  input  logic              serial_clk_in,
  input  logic              serial_data_in,
  output logic              serial_clk_out,
  output logic              serial_data_out,
  output logic [DATA_W-1:0] sb,
  output logic              serial_irq,
  output logic              sc_start,
  output logic              sc_int_clock,
  output logic              sc_fast,
  output logic              busy
);

  localparam int unsigned DIV_MAX = (DIV_NORMAL > DIV_FAST) ? DIV_NORMAL : DIV_FAST;
  localparam int unsigned DIV_W   = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam int unsigned CNT_W   = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StIntLow, StIntHigh, StExtWait} state_e;

  state_e                 r_state, w_state_next;
  logic [DIV_W-1:0]       r_div;
  logic [CNT_W-1:0]       r_cnt;
  logic [DATA_W-1:0]      r_sb;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sc_start, r_sc_int_clock, r_sc_fast;
  logic                   r_clk_out, r_data_out, r_irq;

  logic              w_sc_wr, w_sb_wr, w_start;
  logic              w_div_zero, w_last, w_sync_rise, w_sync_fall;
  logic              w_int_fall, w_int_rise, w_ext_out, w_ext_shift, w_shift, w_busy;
  logic [DIV_W-1:0]  w_reload, w_reload_start;
  logic [DATA_W-1:0] w_sb_shift;

  assign w_sc_wr    = sel_sc & ~cpu_wr_n;
  assign w_sb_wr    = sel_sb & ~cpu_wr_n;
  assign w_start    = w_sc_wr & sc_start_in;
  assign w_div_zero = (r_div == '0);
  assign w_last     = (r_cnt == CNT_W'(1));
  // Oldest two synchroniser stages; stage 0 is the newest sample.
  assign w_sync_rise = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
  assign w_sync_fall = ~r_sync[SYNC_STAGES-2] & r_sync[SYNC_STAGES-1];
  assign w_reload       = r_sc_fast  ? DIV_W'(DIV_FAST) : DIV_W'(DIV_NORMAL);
  assign w_reload_start = sc_fast_in ? DIV_W'(DIV_FAST) : DIV_W'(DIV_NORMAL);
  // Truncating cast drops the MSB; for DATA_W=1 this leaves just serial_data_in.
  assign w_sb_shift = DATA_W'({r_sb, serial_data_in});

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state logic; any SC write overrides the running transfer.
  always_comb begin
    w_state_next = r_state;
    if (w_sc_wr) begin
      if (sc_start_in) w_state_next = sc_int_clock_in ? StIntHigh : StExtWait;
      else             w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIntHigh: if (w_div_zero) w_state_next = StIntLow;
        StIntLow:  if (w_div_zero) w_state_next = w_last ? StIdle : StIntHigh;
        StExtWait: if (w_sync_rise && w_last) w_state_next = StIdle;
        default:   w_state_next = r_state;
      endcase
    end
  end

  // Output / action decode
  always_comb begin
    w_busy      = (r_state != StIdle);
    w_int_fall  = 1'b0;
    w_int_rise  = 1'b0;
    w_ext_out   = 1'b0;
    w_ext_shift = 1'b0;
    if (!w_sc_wr) begin
      unique case (r_state)
        StIntHigh: w_int_fall = w_div_zero;
        StIntLow:  w_int_rise = w_div_zero;
        StExtWait: begin
          w_ext_out   = w_sync_fall;
          w_ext_shift = w_sync_rise;
        end
        default: w_busy = 1'b0;
      endcase
    end
    w_shift = w_int_rise | w_ext_shift;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div          <= '0;
      r_cnt          <= '0;
      r_sb           <= '0;
      r_sync         <= {SYNC_STAGES{serial_clk_in}};
      r_sc_start     <= 1'b0;
      r_sc_int_clock <= 1'b0;
      r_sc_fast      <= 1'b0;
      r_clk_out      <= 1'b1;
      r_data_out     <= 1'b1;
      r_irq          <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      // Preloading with the live pin value stops a stale level looking like an edge.
      r_sync <= w_start ? {SYNC_STAGES{serial_clk_in}}
                        : {r_sync[SYNC_STAGES-2:0], serial_clk_in};

      if (w_start) begin
        r_div <= w_reload_start;
      end else if (r_state == StIntHigh || r_state == StIntLow) begin
        r_div <= w_div_zero ? w_reload : r_div - DIV_W'(1);
      end

      if (w_sc_wr) begin
        r_sc_start     <= sc_start_in;
        r_sc_int_clock <= sc_int_clock_in;
        r_sc_fast      <= sc_fast_in;
        r_clk_out      <= 1'b1;
        if (sc_start_in) r_cnt <= CNT_W'(DATA_W);
      end

      if (w_int_fall) begin
        r_clk_out  <= 1'b0;
        r_data_out <= r_sb[DATA_W-1];
      end
      if (w_ext_out) r_data_out <= r_sb[DATA_W-1];

      if (w_shift) begin
        r_sb  <= w_sb_shift;
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_int_rise) r_clk_out <= 1'b1;
        if (w_last) begin
          r_irq      <= 1'b1;
          r_sc_start <= 1'b0;
        end
      end

      // A CPU load wins over a shift landing in the same cycle.
      if (w_sb_wr) r_sb <= sb_in;
    end
  end

  assign serial_clk_out  = r_clk_out;
  assign serial_data_out = r_data_out;
  assign sb              = r_sb;
  assign serial_irq      = r_irq;
  assign sc_start        = r_sc_start;
  assign sc_int_clock    = r_sc_int_clock;
  assign sc_fast         = r_sc_fast;
  assign busy            = w_busy;

endmodule

// File: tb/tb_serial_link_gen2.sv
// Testbench for serial_link_gen2: table of internal-clock transfers plus directed
// sequences for external clock, abort, mid-transfer SB write, reset and DATA_W=1.
`timescale 1ns/1ps
module tb_serial_link_gen2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_sc, sel_sb, cpu_wr_n, sc_start_in, sc_int_clock_in, sc_fast_in;
  logic [7:0] sb_in;
  logic       serial_clk_in, serial_data_in;
  logic       serial_clk_out, serial_data_out, serial_irq;
  logic [7:0] sb;
  logic       sc_start, sc_int_clock, sc_fast, busy;

  // Second instance: DATA_W=1, DIV_NORMAL=3
  logic       b_sel_sc, b_sel_sb, b_wr_n, b_start, b_int, b_fast;
  logic [0:0] b_sb_in, b_sb;
  logic       b_sclk_in, b_sdata_in, b_sclk_out, b_sdata_out, b_irq;
  logic       b_sc_start, b_sc_int, b_sc_fast, b_busy;

  always #5 clk = ~clk;

  serial_link_gen2 u_dut (
    .clk(clk), .rst(rst), .sel_sc(sel_sc), .sel_sb(sel_sb), .cpu_wr_n(cpu_wr_n),
    .sc_start_in(sc_start_in), .sc_int_clock_in(sc_int_clock_in), .sc_fast_in(sc_fast_in),
    .sb_in(sb_in), .serial_clk_in(serial_clk_in), .serial_data_in(serial_data_in),
    .serial_clk_out(serial_clk_out), .serial_data_out(serial_data_out), .sb(sb),
    .serial_irq(serial_irq), .sc_start(sc_start), .sc_int_clock(sc_int_clock),
    .sc_fast(sc_fast), .busy(busy)
  );

  serial_link_gen2 #(.DATA_W(1), .DIV_NORMAL(3), .DIV_FAST(1), .SYNC_STAGES(3)) u_dut1 (
    .clk(clk), .rst(rst), .sel_sc(b_sel_sc), .sel_sb(b_sel_sb), .cpu_wr_n(b_wr_n),
    .sc_start_in(b_start), .sc_int_clock_in(b_int), .sc_fast_in(b_fast),
    .sb_in(b_sb_in), .serial_clk_in(b_sclk_in), .serial_data_in(b_sdata_in),
    .serial_clk_out(b_sclk_out), .serial_data_out(b_sdata_out), .sb(b_sb),
    .serial_irq(b_irq), .sc_start(b_sc_start), .sc_int_clock(b_sc_int),
    .sc_fast(b_sc_fast), .busy(b_busy)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic cpu_write(input logic wsc, input logic wsb, input logic st, input logic ic,
                           input logic fs, input logic [7:0] d);
    @(negedge clk);
    sel_sc = wsc; sel_sb = wsb; cpu_wr_n = 1'b0;
    sc_start_in = st; sc_int_clock_in = ic; sc_fast_in = fs; sb_in = d;
    @(posedge clk);
    #1;
    sel_sc = 1'b0; sel_sb = 1'b0; cpu_wr_n = 1'b1;
  endtask

  // Observes outputs at each negedge; n counts clock edges after the write edge.
  task automatic watch(input int budget, output int fall_cyc, output int irq_cyc,
                       output int irq_cnt, output logic [7:0] bits,
                       output logic [7:0] sb_at_irq, output logic start_at_irq);
    logic prev_clk;
    fall_cyc = -1; irq_cyc = -1; irq_cnt = 0; bits = '0;
    sb_at_irq = '0; start_at_irq = 1'b1; prev_clk = 1'b1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (prev_clk && !serial_clk_out) begin
        if (fall_cyc < 0) fall_cyc = n;
        bits = {bits[6:0], serial_data_out};
      end
      prev_clk = serial_clk_out;
      if (serial_irq) begin
        irq_cnt++;
        if (irq_cyc < 0) begin
          irq_cyc = n; sb_at_irq = sb; start_at_irq = sc_start;
        end
      end
      if (irq_cyc >= 0 && n >= irq_cyc + 3) break;
    end
  endtask

  typedef struct {
    logic [7:0] sb0;
    logic       fast;
    logic       din;
    int         exp_fall;
    int         exp_irq;
    logic [7:0] exp_sb;
    logic [7:0] exp_bits;
  } vec_t;

  vec_t       vecs[4];
  int         w_fall, w_irq, w_cnt;
  logic [7:0] w_bits, w_sb;
  logic       w_st;
  logic [7:0] ext_bits, ext_pattern;
  logic       clk_low_seen;
  int         irq_seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 512, 8192, 8'hFF, 8'hA5};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 16, 256, 8'h00, 8'hA5};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 16, 256, 8'hFF, 8'h3C};
    vecs[3] = '{8'h5A, 1'b1, 1'b0, 16, 256, 8'h00, 8'h5A};

    rst = 1'b1; sel_sc = 0; sel_sb = 0; cpu_wr_n = 1; sc_start_in = 0;
    sc_int_clock_in = 0; sc_fast_in = 0; sb_in = 0; serial_clk_in = 1; serial_data_in = 0;
    b_sel_sc = 0; b_sel_sb = 0; b_wr_n = 1; b_start = 0; b_int = 0; b_fast = 0;
    b_sb_in = 0; b_sclk_in = 1; b_sdata_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sb", sb, 8'h00);
    chk("rst_sc_start", sc_start, 0);
    chk("rst_sc_int", sc_int_clock, 0);
    chk("rst_sc_fast", sc_fast, 0);
    chk("rst_clk_out", serial_clk_out, 1);
    chk("rst_data_out", serial_data_out, 1);
    chk("rst_irq", serial_irq, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Internal-clock transfers; SB and SC written in the same cycle.
    for (int i = 0; i < 4; i++) begin
      serial_data_in = vecs[i].din;
      cpu_write(1'b1, 1'b1, 1'b1, 1'b1, vecs[i].fast, vecs[i].sb0);
      watch(9000, w_fall, w_irq, w_cnt, w_bits, w_sb, w_st);
      chk($sformatf("v%0d_first_fall", i), w_fall, vecs[i].exp_fall);
      chk($sformatf("v%0d_irq_cycle", i), w_irq, vecs[i].exp_irq);
      chk($sformatf("v%0d_irq_count", i), w_cnt, 1);
      chk($sformatf("v%0d_sb", i), w_sb, vecs[i].exp_sb);
      chk($sformatf("v%0d_bits", i), w_bits, vecs[i].exp_bits);
      chk($sformatf("v%0d_start_at_irq", i), w_st, 0);
      chk($sformatf("v%0d_busy_after", i), busy, 0);
      chk($sformatf("v%0d_sc_fast", i), sc_fast, vecs[i].fast);
      chk($sformatf("v%0d_sc_int", i), sc_int_clock, 1);
    end

    // External clock: 8 pulses carrying 0x96.
    ext_pattern = 8'h96; ext_bits = '0; clk_low_seen = 1'b0;
    cpu_write(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          serial_clk_in = 1'b0;
          serial_data_in = ext_pattern[7-i];
          repeat (20) @(negedge clk);
          ext_bits = {ext_bits[6:0], serial_data_out};
          if (!serial_clk_out) clk_low_seen = 1'b1;
          serial_clk_in = 1'b1;
          repeat (20) @(negedge clk);
        end
      end
      watch(400, w_fall, w_irq, w_cnt, w_bits, w_sb, w_st);
    join
    chk("ext_sb", sb, 8'h96);
    chk("ext_irq_count", w_cnt, 1);
    chk("ext_bits", ext_bits, 8'h3C);
    chk("ext_clk_out_no_fall", w_fall, -1);
    chk("ext_clk_out_low_seen", clk_low_seen, 0);
    chk("ext_start_at_irq", w_st, 0);
    chk("ext_busy_after", busy, 0);
    chk("ext_sc_int", sc_int_clock, 0);

    // Idle: external edges ignored.
    serial_data_in = 1'b1;
    irq_seen = 0;
    for (int i = 0; i < 4; i++) begin
      serial_clk_in = ~serial_clk_in;
      repeat (10) begin
        @(negedge clk);
        if (serial_irq) irq_seen++;
      end
    end
    chk("idle_sb", sb, 8'h96);
    chk("idle_irq", irq_seen, 0);
    chk("idle_busy", busy, 0);
    chk("idle_data_out", serial_data_out, 0);

    // Abort at cycle 3000.
    serial_data_in = 1'b1;
    cpu_write(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5);
    repeat (2998) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_clk_low", serial_clk_out, 0);
    chk("abort_pre_busy", busy, 1);
    cpu_write(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_clk_out", serial_clk_out, 1);
    chk("abort_sb_partial", sb, 8'h97);
    chk("abort_sc_start", sc_start, 0);
    irq_seen = 0;
    repeat (7000) begin
      @(negedge clk);
      if (serial_irq) irq_seen++;
    end
    chk("abort_no_irq", irq_seen, 0);

    // SB write mid-transfer, then reset mid-transfer.
    serial_data_in = 1'b0;
    cpu_write(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    repeat (3998) @(posedge clk);
    @(negedge clk);
    chk("sbw_pre_data_out", serial_data_out, 1);
    cpu_write(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("sbw_sb", sb, 8'h00);
    chk("sbw_busy", busy, 1);
    repeat (608) @(posedge clk);
    @(negedge clk);
    chk("sbw_clk_fall", serial_clk_out, 0);
    chk("sbw_new_bit", serial_data_out, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_sb", sb, 8'h00);
    chk("rst2_sc_start", sc_start, 0);
    chk("rst2_sc_int", sc_int_clock, 0);
    chk("rst2_sc_fast", sc_fast, 0);
    chk("rst2_clk_out", serial_clk_out, 1);
    chk("rst2_data_out", serial_data_out, 1);
    chk("rst2_irq", serial_irq, 0);
    chk("rst2_busy", busy, 0);
    irq_seen = 0;
    repeat (4000) begin
      @(negedge clk);
      if (serial_irq) irq_seen++;
    end
    chk("rst2_no_irq", irq_seen, 0);

    // DATA_W=1, DIV_NORMAL=3.
    b_sdata_in = 1'b1;
    @(negedge clk);
    b_sel_sc = 1'b1; b_wr_n = 1'b0; b_start = 1'b1; b_int = 1'b1; b_fast = 1'b0;
    @(posedge clk);
    #1 b_sel_sc = 1'b0; b_wr_n = 1'b1;
    w_fall = -1; w_irq = -1; w_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!b_sclk_out && w_fall < 0) w_fall = n;
      if (b_irq) begin
        w_cnt++;
        if (w_irq < 0) w_irq = n;
      end
    end
    chk("w1_first_fall", w_fall, 4);
    chk("w1_irq_cycle", w_irq, 8);
    chk("w1_irq_count", w_cnt, 1);
    chk("w1_sb", b_sb, 1);
    chk("w1_busy_after", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
